// File: rtl/bigaddsub_limb.sv
// One pipeline stage of the wide adder: a registered LW-bit add with carry in/out.
// The sum and carry hold while i_ce is low; reset clears both regardless of i_ce.
module bigaddsub_limb #(
  parameter int LW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic [LW-1:0] i_a,
  input  logic [LW-1:0] i_b,
  input  logic          i_c,
  output logic [LW-1:0] o_s,
  output logic          o_c
);

  logic [LW:0]   w_sum;
  logic [LW-1:0] r_s;
  logic          r_c;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{LW{1'b0}}, i_c};

  // limb sum and carry register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s <= {LW{1'b0}};
      r_c <= 1'b0;
    end else if (i_ce) begin
      r_s <= w_sum[LW-1:0];
      r_c <= w_sum[LW];
    end
  end

  assign o_s = r_s;
  assign o_c = r_c;

endmodule

// File: rtl/bigaddsub.sv
// Pipelined wide add/subtract: one limb's carry is resolved per enabled cycle,
// with triangular delay (operands) and alignment (results) registers around the limbs.
module bigaddsub #(
  parameter int DW = 64,
  parameter int LW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_sync,
  input  logic          i_sub,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_r,
  output logic          o_carry,
  output logic          o_ovfl,
  output logic          o_sync
);

  localparam int NL = DW / LW;

  // A partial top limb would silently drop bits, so refuse to elaborate.
  if ((DW % LW) != 0) begin : g_bad_width
    $error("bigaddsub: DW must be an integer multiple of LW");
  end

  logic [DW-1:0] w_b;
  logic [NL:0]   w_c;
  logic [DW-1:0] w_r;
  logic [NL-1:0] r_sync;
  logic [NL-1:0] r_amsb;
  logic [NL-1:0] r_bmsb;

  // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry.
  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_c[0] = i_sub;

  // sync tag and operand sign bits travel the full pipeline depth
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {NL{1'b0}};
      r_amsb <= {NL{1'b0}};
      r_bmsb <= {NL{1'b0}};
    end else if (i_ce) begin
      r_sync[0] <= i_sync;
      r_amsb[0] <= i_a[DW-1];
      r_bmsb[0] <= w_b[DW-1];
      for (int j = 1; j < NL; j++) begin
        r_sync[j] <= r_sync[j-1];
        r_amsb[j] <= r_amsb[j-1];
        r_bmsb[j] <= r_bmsb[j-1];
      end
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_limb
    logic [LW-1:0] w_ak;
    logic [LW-1:0] w_bk;
    logic [LW-1:0] w_sk;

    if (k == 0) begin : g_direct
      assign w_ak = i_a[LW-1:0];
      assign w_bk = w_b[LW-1:0];
    end else begin : g_delay
      logic [LW-1:0] r_ad [k];
      logic [LW-1:0] r_bd [k];

      // operand limb k waits k enabled cycles for its carry to arrive
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int j = 0; j < k; j++) begin
            r_ad[j] <= {LW{1'b0}};
            r_bd[j] <= {LW{1'b0}};
          end
        end else if (i_ce) begin
          r_ad[0] <= i_a[k*LW +: LW];
          r_bd[0] <= w_b[k*LW +: LW];
          for (int j = 1; j < k; j++) begin
            r_ad[j] <= r_ad[j-1];
            r_bd[j] <= r_bd[j-1];
          end
        end
      end

      assign w_ak = r_ad[k-1];
      assign w_bk = r_bd[k-1];
    end

    bigaddsub_limb #(
      .LW(LW)
    ) u_limb (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_ce   (i_ce),
      .i_a    (w_ak),
      .i_b    (w_bk),
      .i_c    (w_c[k]),
      .o_s    (w_sk),
      .o_c    (w_c[k+1])
    );

    if (k == NL-1) begin : g_last
      assign w_r[k*LW +: LW] = w_sk;
    end else begin : g_align
      logic [LW-1:0] r_al [NL-1-k];

      // finished limb k waits for the upper limbs of its own sample
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int j = 0; j < NL-1-k; j++) begin
            r_al[j] <= {LW{1'b0}};
          end
        end else if (i_ce) begin
          r_al[0] <= w_sk;
          for (int j = 1; j < NL-1-k; j++) begin
            r_al[j] <= r_al[j-1];
          end
        end
      end

      assign w_r[k*LW +: LW] = r_al[NL-2-k];
    end
  end

  assign o_r     = w_r;
  assign o_carry = w_c[NL];
  assign o_sync  = r_sync[NL-1];
  assign o_ovfl  = (r_amsb[NL-1] == r_bmsb[NL-1]) && (w_r[DW-1] != r_amsb[NL-1]);

endmodule

// File: tb/tb_bigaddsub.sv
// Scoreboard bench: three instances (NL=2, 4, 1) share stimulus; expected results come
// from plain wide arithmetic and are popped by a monitor on every enabled edge.
module tb_bigaddsub;

  logic        clk = 1'b0;
  logic        i_reset, i_ce, i_sync, i_sub;
  logic [63:0] i_a, i_b;

  logic [63:0] r32, r16, r64;
  logic        c32, c16, c64, v32, v16, v64, s32, s16, s64;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
    logic        s;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t q64[$];
  exp_t last32, last16, last64;

  int   checks = 0;
  int   errors = 0;
  logic mon_on = 1'b0;
  logic ce_s, rst_s;

  always #5 clk = ~clk;

  bigaddsub #(.DW(64), .LW(32)) u_dut32 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_sub(i_sub),
    .i_a(i_a), .i_b(i_b), .o_r(r32), .o_carry(c32), .o_ovfl(v32), .o_sync(s32));

  bigaddsub #(.DW(64), .LW(16)) u_dut16 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_sub(i_sub),
    .i_a(i_a), .i_b(i_b), .o_r(r16), .o_carry(c16), .o_ovfl(v16), .o_sync(s16));

  bigaddsub #(.DW(64), .LW(64)) u_dut64 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync), .i_sub(i_sub),
    .i_a(i_a), .i_b(i_b), .o_r(r64), .o_carry(c64), .o_ovfl(v64), .o_sync(s64));

  function automatic exp_t model(logic sub, logic [63:0] a, logic [63:0] b, logic s);
    exp_t               e;
    logic        [64:0] full;
    logic signed [65:0] x;
    if (sub) begin
      e.r = a - b;
      e.c = (a >= b);
      x   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      full = {1'b0, a} + {1'b0, b};
      e.r  = full[63:0];
      e.c  = full[64];
      x    = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    end
    // overflow when the exact signed result does not fit in 64 bits
    e.v = (x[65:63] != {3{x[63]}});
    e.s = s;
    return e;
  endfunction

  task automatic check(string nm, logic [63:0] r, logic c, logic v, logic s, exp_t e);
    checks++;
    if ({r, c, v, s} !== {e.r, e.c, e.v, e.s}) begin
      errors++;
      $display("FAIL %s t=%0t got r=%h c=%b v=%b s=%b expected r=%h c=%b v=%b s=%b",
               nm, $time, r, c, v, s, e.r, e.c, e.v, e.s);
    end
  endtask

  task automatic pop_one(string nm, inout exp_t q[$], inout exp_t last);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue got empty expected an entry", nm);
    end else begin
      last = q.pop_front();
    end
  endtask

  // monitor: on enabled edges the next expected sample becomes current; on held
  // edges the outputs must still show the previous one
  always @(posedge clk) begin
    ce_s  = i_ce;
    rst_s = i_reset;
    #1;
    if (mon_on && !rst_s) begin
      if (ce_s) begin
        pop_one("nl2", q32, last32);
        pop_one("nl4", q16, last16);
        pop_one("nl1", q64, last64);
      end
      check("nl2", r32, c32, v32, s32, last32);
      check("nl4", r16, c16, v16, s16, last16);
      check("nl1", r64, c64, v64, s64, last64);
    end
  end

  task automatic drive(logic ce, logic sub, logic [63:0] a, logic [63:0] b, logic s);
    exp_t e;
    @(negedge clk);
    i_reset = 1'b0;
    i_ce    = ce;
    i_sub   = sub;
    i_a     = a;
    i_b     = b;
    i_sync  = s;
    if (ce) begin
      e = model(sub, a, b, s);
      q32.push_back(e);
      q16.push_back(e);
      q64.push_back(e);
    end
  endtask

  // A cleared pipeline presents all-zero outputs until real samples have moved through.
  task automatic do_reset(logic ce);
    exp_t z;
    z = '0;
    @(negedge clk);
    i_reset = 1'b1;
    i_ce    = ce;
    i_sync  = 1'b1;
    i_sub   = 1'b1;
    i_a     = {$urandom(), $urandom()};
    i_b     = {$urandom(), $urandom()};
    q32.delete();
    q16.delete();
    q64.delete();
    q32.push_back(z);
    for (int i = 0; i < 3; i++) q16.push_back(z);
    last32 = z;
    last16 = z;
    last64 = z;
    @(posedge clk);
    #1;
    check("rst_nl2", r32, c32, v32, s32, z);
    check("rst_nl4", r16, c16, v16, s16, z);
    check("rst_nl1", r64, c64, v64, s64, z);
  endtask

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h0000_0000_0000_0000;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h7FFF_FFFF_FFFF_FFFF;
      3: v = 64'h8000_0000_0000_0000;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    i_reset = 1'b0;
    i_ce    = 1'b0;
    i_sync  = 1'b0;
    i_sub   = 1'b0;
    i_a     = 64'h0;
    i_b     = 64'h0;
    do_reset(1'b1);
    mon_on = 1'b1;

    drive(1'b1, 1'b1, 64'h0000_0001_0000_0000, 64'h1, 1'b1);
    drive(1'b1, 1'b1, 64'h0, 64'h1, 1'b0);
    drive(1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    drive(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(1'b1, 1'b1, 64'h0000_0000_0001_0000, 64'h1, 1'b0);
    drive(1'b1, 1'b0, 64'd5, 64'd7, 1'b1);
    drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
    drive(1'b1, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);

    // alternate add/sub every cycle at full rate
    for (int i = 0; i < 4000; i++) begin
      drive(1'b1, i[0], pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    // sparse clock enable, roughly 30% duty
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
            pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    // tagged sample followed by reset (with i_ce low) must never emerge
    drive(1'b1, 1'b0, pick_operand(), pick_operand(), 1'b1);
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, pick_operand(), pick_operand(), 1'b0);

    // reset in the middle of a full-rate stream
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, pick_operand(), pick_operand(), 1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
